// File: rtl/vga_scanout.sv
// vga_scanout: continuous framebuffer reader and VGA raster generator.
// Each stored pixel is replicated (1 << SCALE_SHIFT) times horizontally
// and vertically. Raster state advances once per two clk cycles. Colour,
// sync and blank all reach the DAC pins through the same single
// pixel-period stage, so they stay aligned.
module vga_scanout #(
  parameter int unsigned H_VIS       = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VIS       = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned FB_W        = 160,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [14:0] mem_addr,
  input  logic [2:0]  mem_q,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        frame_start,
  output logic        vblank
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT + 1);
  localparam int unsigned VW    = $clog2(V_TOT + 1);
  localparam int unsigned AW    = 15;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);

  // pixel-rate divider and "raster running" flag
  logic          phase_q, phase_d;
  logic          run_q, run_d;
  logic          pix_en;

  // raster counters (value most recently loaded)
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  // address stage: read address plus the timing of the pixel it fetches
  logic [AW-1:0] addr_q, addr_d;
  logic          hs1_q, hs1_d;
  logic          vs1_q, vs1_d;
  logic          vis1_q, vis1_d;

  // output stage
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_n_q, blank_n_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          frame_start_q, frame_start_d;
  logic          vblank_q, vblank_d;

  // next raster position and its decode
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          wrap;
  logic          vis_nxt;
  logic          hs_n_nxt;
  logic          vs_n_nxt;
  logic          vblank_nxt;
  logic [HW-1:0] h_blk;
  logic [VW-1:0] v_blk;
  logic [AW-1:0] row_base;
  logic [AW-1:0] addr_nxt;

  assign pix_en = phase_q;

  // Next counter value. The first pixel edge after reset loads (0,0)
  // rather than advancing, so a fresh raster never skips its first pixel.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    wrap  = 1'b0;
    if (run_q) begin
      if (h_cnt_q == H_LAST) begin
        if (v_cnt_q == V_LAST) begin
          wrap = 1'b1;
        end else begin
          v_nxt = v_cnt_q + VW'(1);
        end
      end else begin
        h_nxt = h_cnt_q + HW'(1);
        v_nxt = v_cnt_q;
      end
    end
  end

  // Visible/sync/vblank decode of the position about to be loaded
  always_comb begin
    vis_nxt    = (h_nxt < H_VIS_C) && (v_nxt < V_VIS_C);
    hs_n_nxt   = !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
    vs_n_nxt   = !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
    vblank_nxt = (v_nxt >= V_VIS_C);
    h_blk      = h_nxt >> SCALE_SHIFT;
    v_blk      = v_nxt >> SCALE_SHIFT;
  end

  // Row base address; the 160-wide framebuffer uses (<<7)+(<<5)
  if (FB_W == 160) begin : g_row_shift_add
    always_comb row_base = (AW'(v_blk) << 7) + (AW'(v_blk) << 5);
  end else begin : g_row_mul
    always_comb row_base = AW'(v_blk) * AW'(FB_W);
  end

  // Full framebuffer address of the next pixel
  always_comb addr_nxt = row_base + AW'(h_blk);

  // Next-state for all registers; everything but phase waits for pix_en
  always_comb begin
    phase_d       = ~phase_q;
    run_d         = run_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    addr_d        = addr_q;
    hs1_d         = hs1_q;
    vs1_d         = vs1_q;
    vis1_d        = vis1_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    rgb_d         = rgb_q;
    vblank_d      = vblank_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      run_d         = 1'b1;
      h_cnt_d       = h_nxt;
      v_cnt_d       = v_nxt;
      addr_d        = vis_nxt ? addr_nxt : '0;
      hs1_d         = hs_n_nxt;
      vs1_d         = vs_n_nxt;
      vis1_d        = vis_nxt;
      vblank_d      = vblank_nxt;
      frame_start_d = wrap;
      // mem_q now holds the data for the address issued one period ago
      hs_d          = hs1_q;
      vs_d          = vs1_q;
      blank_n_d     = vis1_q;
      rgb_d         = vis1_q ? mem_q : '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q       <= 1'b0;
      run_q         <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      addr_q        <= '0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      vis1_q        <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      run_q         <= run_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      addr_q        <= addr_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      vis1_q        <= vis1_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      rgb_q         <= rgb_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign mem_addr    = addr_q;
  assign VGA_CLK     = phase_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_R       = {10{rgb_q[2]}};
  assign VGA_G       = {10{rgb_q[1]}};
  assign VGA_B       = {10{rgb_q[0]}};
  assign frame_start = frame_start_q;
  assign vblank      = vblank_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench for vga_scanout. Horizontal timing is the
// full 640x480 line; the vertical geometry is shortened (8 visible lines,
// 12 total) so whole frames fit in a short run.
module tb_vga_scanout;

  localparam int LINE_CLK  = 1600;
  localparam int V_TOT_T   = 12;
  localparam int FRAME_CLK = LINE_CLK * V_TOT_T;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [14:0] mem_addr;
  logic [2:0]  mem_q = 3'b000;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0]  VGA_R, VGA_G, VGA_B;
  logic        frame_start, vblank;

  int n_checks = 0;
  int n_fail   = 0;
  int k_now    = 0;

  vga_scanout #(
    .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FB_W(160), .SCALE_SHIFT(2)
  ) dut (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_q(mem_q),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .frame_start(frame_start), .vblank(vblank)
  );

  always #10 clk = ~clk;

  // framebuffer model: 1-clk read latency, 3'b101 at address 1 only
  always @(posedge clk) mem_q <= (mem_addr == 15'd1) ? 3'b101 : 3'b010;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // advance to just after the pixel edge that loads raster index k
  task automatic goto_k(input int k);
    step(2 * (k - k_now));
    k_now = k;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(3);
    @(negedge clk); resetn = 1'b1;
    step(2 + 2 * 10);
    n_checks++;
    if (VGA_BLANK_N !== 1'b1) begin n_fail++; $display("FAIL pre_reset_visible: got %b expected 1", VGA_BLANK_N); end
    @(negedge clk); resetn = 1'b0; #1;
    n_checks++;
    if ({VGA_HS, VGA_VS, VGA_BLANK_N} !== 3'b110) begin n_fail++; $display("FAIL reset_hs_vs_blank: got %b expected 110", {VGA_HS, VGA_VS, VGA_BLANK_N}); end
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 30'h0) begin n_fail++; $display("FAIL reset_rgb: got %h expected 0", {VGA_R, VGA_G, VGA_B}); end
    n_checks++;
    if (mem_addr !== 15'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    n_checks++;
    if ({frame_start, vblank, VGA_CLK} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b expected 000", {frame_start, vblank, VGA_CLK}); end
    n_checks++;
    if (VGA_SYNC_N !== 1'b1) begin n_fail++; $display("FAIL sync_n: got %b expected 1", VGA_SYNC_N); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    step(1);
    n_checks++;
    if ({VGA_CLK, VGA_BLANK_N} !== 2'b10) begin n_fail++; $display("FAIL post_release_clk1: got %b expected 10", {VGA_CLK, VGA_BLANK_N}); end
    step(1);
    n_checks++;
    if ({VGA_CLK, frame_start, mem_addr} !== {2'b00, 15'd0}) begin n_fail++; $display("FAIL first_pix_edge: got %h expected 0", {VGA_CLK, frame_start, mem_addr}); end
    step(1);
    n_checks++;
    if (VGA_BLANK_N !== 1'b0) begin n_fail++; $display("FAIL blank_before_pixel0: got %b expected 0", VGA_BLANK_N); end
    step(1);
    n_checks++;
    if ({VGA_BLANK_N, VGA_HS, VGA_VS, VGA_CLK, VGA_SYNC_N} !== 5'b11101) begin n_fail++; $display("FAIL pixel0_out: got %b expected 11101", {VGA_BLANK_N, VGA_HS, VGA_VS, VGA_CLK, VGA_SYNC_N}); end
    k_now = 1;
  endtask

  task automatic test_colour();
    int       ks[9]  = '{4, 5, 6, 7, 8, 9, 640, 641, 700};
    logic [2:0] cs[9] = '{3'b010, 3'b101, 3'b101, 3'b101, 3'b101, 3'b010, 3'b010, 3'b000, 3'b000};
    logic       bs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [29:0] exp_rgb;
    for (int i = 0; i < 9; i++) begin
      goto_k(ks[i]);
      if (ks[i] == 4) begin
        n_checks++;
        if (mem_addr !== 15'd1) begin n_fail++; $display("FAIL colour_issue_addr: got %0d expected 1", mem_addr); end
      end
      exp_rgb = {{10{cs[i][2]}}, {10{cs[i][1]}}, {10{cs[i][0]}}};
      n_checks++;
      if ({VGA_R, VGA_G, VGA_B} !== exp_rgb) begin n_fail++; $display("FAIL colour_k%0d: got %h expected %h", ks[i], {VGA_R, VGA_G, VGA_B}, exp_rgb); end
      n_checks++;
      if (VGA_BLANK_N !== bs[i]) begin n_fail++; $display("FAIL blank_k%0d: got %b expected %b", ks[i], VGA_BLANK_N, bs[i]); end
    end
  endtask

  task automatic test_horizontal();
    int blank_cnt = 0, hs_cnt = 0;
    int rise1 = -1, rise2 = -1, fall = -1;
    logic prev_b, prev_h;
    goto_k(800);
    prev_b = VGA_BLANK_N;
    prev_h = VGA_HS;
    for (int j = 1; j <= 801; j++) begin
      goto_k(800 + j);
      if (j <= 800) begin
        if (VGA_BLANK_N === 1'b1) blank_cnt++;
        if (VGA_HS === 1'b0) hs_cnt++;
      end
      if (prev_b === 1'b0 && VGA_BLANK_N === 1'b1) begin
        if (rise1 < 0) rise1 = j; else if (rise2 < 0) rise2 = j;
      end
      if (prev_h === 1'b1 && VGA_HS === 1'b0 && fall < 0) fall = j;
      prev_b = VGA_BLANK_N;
      prev_h = VGA_HS;
    end
    n_checks++;
    if (blank_cnt != 640) begin n_fail++; $display("FAIL h_visible_periods: got %0d expected 640", blank_cnt); end
    n_checks++;
    if (hs_cnt != 96) begin n_fail++; $display("FAIL hs_low_periods: got %0d expected 96", hs_cnt); end
    n_checks++;
    if (fall - rise1 != 656) begin n_fail++; $display("FAIL hs_fall_offset: got %0d expected 656", fall - rise1); end
    n_checks++;
    if (2 * (rise2 - rise1) != LINE_CLK) begin n_fail++; $display("FAIL line_period_clk: got %0d expected %0d", 2 * (rise2 - rise1), LINE_CLK); end
  endtask

  task automatic test_address();
    int         ks[8] = '{0, 4, 640, 2403, 3200, 6239, 6399, 6400};
    logic [14:0] as[8] = '{15'd0, 15'd1, 15'd0, 15'd0, 15'd160, 15'd319, 15'd0, 15'd0};
    logic       vs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk); resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    step(2);
    k_now = 0;
    for (int i = 0; i < 8; i++) begin
      goto_k(ks[i]);
      n_checks++;
      if (mem_addr !== as[i]) begin n_fail++; $display("FAIL addr_k%0d: got %0d expected %0d", ks[i], mem_addr, as[i]); end
      n_checks++;
      if (vblank !== vs[i]) begin n_fail++; $display("FAIL vblank_k%0d: got %b expected %b", ks[i], vblank, vs[i]); end
    end
    goto_k(6401);
    n_checks++;
    if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== 31'h0) begin n_fail++; $display("FAIL v480_blank: got %h expected 0", {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}); end
  endtask

  task automatic test_frame();
    int n = 0, vs_low = 0, vb_hi = 0;
    bit found = 0;
    for (int i = 0; i < FRAME_CLK + 100; i++) begin
      step(1);
      if (frame_start === 1'b1) begin found = 1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL frame_start_first: got none expected pulse"); end
    found = 0;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      step(1);
      n++;
      if (VGA_VS === 1'b0) vs_low++;
      if (vblank === 1'b1) vb_hi++;
      if (frame_start === 1'b1) begin found = 1; break; end
    end
    n_checks++;
    if (!found || n != FRAME_CLK) begin n_fail++; $display("FAIL frame_period: got %0d expected %0d", n, FRAME_CLK); end
    n_checks++;
    if (vs_low != 2 * LINE_CLK) begin n_fail++; $display("FAIL vs_low_clk: got %0d expected %0d", vs_low, 2 * LINE_CLK); end
    n_checks++;
    if (vb_hi != 4 * LINE_CLK) begin n_fail++; $display("FAIL vblank_clk: got %0d expected %0d", vb_hi, 4 * LINE_CLK); end
    step(1);
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL frame_start_width: got %b expected 0", frame_start); end
  endtask

  task automatic test_reset_midline();
    int n = 0;
    bit found = 0;
    @(negedge clk); resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    step(2);
    k_now = 0;
    goto_k(4300);
    n_checks++;
    if ({VGA_BLANK_N, mem_addr} !== {1'b1, 15'd235}) begin n_fail++; $display("FAIL midline_state: got %h expected %h", {VGA_BLANK_N, mem_addr}, {1'b1, 15'd235}); end
    @(negedge clk); resetn = 1'b0; #1;
    n_checks++;
    if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, mem_addr, VGA_CLK, vblank} !== {3'b110, 30'h0, 15'd0, 2'b00}) begin
      n_fail++; $display("FAIL midline_async_reset: got %h expected %h", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, mem_addr, VGA_CLK, vblank}, {3'b110, 30'h0, 15'd0, 2'b00});
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    step(2);
    n_checks++;
    if ({frame_start, mem_addr, vblank} !== 17'h0) begin n_fail++; $display("FAIL restart_edge: got %h expected 0", {frame_start, mem_addr, vblank}); end
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      step(1);
      n++;
      if (frame_start === 1'b1) begin found = 1; break; end
    end
    n_checks++;
    if (!found || n != FRAME_CLK) begin n_fail++; $display("FAIL restart_frame_period: got %0d expected %0d", n, FRAME_CLK); end
  endtask

  initial begin
    test_reset();
    test_colour();
    test_horizontal();
    test_address();
    test_frame();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
